// File: rtl/demux_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// demux_scheduler_pkg
// Shared constants and types for the demux scheduler and its round-robin
// lane picker.
//   NUM_LANES : number of output lanes
//   SEL_W     : width of a lane index
//   CNT_W     : width of the delivered-transfer counter
//   state_e   : scheduler FSM state (IDLE = empty, HOLD = one word held)
// -----------------------------------------------------------------------------
package demux_scheduler_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : demux_scheduler_pkg

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin lane picker. Searches the enable mask starting at
// lane (ptr + 1) mod 8, wrapping upward, and returns the first enabled lane.
// The last candidate visited is ptr itself, so a single enabled lane is always
// found even when it was also the previous grant.
// Ports:
//   mask  [8] in  : lane enables, bit i = lane i eligible
//   ptr   [3] in  : last granted lane
//   grant [3] out : chosen lane (0 when nothing is found)
//   found     out : at least one lane is enabled
// -----------------------------------------------------------------------------
module rr_pick8
    import demux_scheduler_pkg::*;
(
    input  logic [NUM_LANES-1:0] mask,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     grant,
    output logic                 found
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the loop leaves a value unassigned (no latch).
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Index arithmetic is SEL_W bits wide, so ptr + k wraps modulo 8.
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && mask[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick8

// File: rtl/demux_scheduler.sv
// -----------------------------------------------------------------------------
// demux_scheduler
// Accepts one W-bit word at a time and forwards it to one of eight output
// lanes chosen round-robin among the enabled lanes. A single output register
// holds the word until the selected lane consumes it; a consume and a new
// accept may happen in the same cycle, giving one word per cycle throughput.
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : asynchronous active-high reset
//   in_valid       in  : input word offered
//   in_data   [W]  in  : input word
//   in_ready       out : input word accepted this cycle (combinational)
//   lane_mask [8]  in  : lane enables for the next grant
//   out_valid [8]  out : one-hot, lane sel holds a word
//   out_data [8W]  out : lane i at bits [i*W +: W], non-selected lanes zero
//   out_ready [8]  in  : lane i consumes its word this cycle
//   sel       [3]  out : lane holding or last granted
//   busy           out : a word is held
//   delivered [16] out : completed lane transfers, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module demux_scheduler
    import demux_scheduler_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    output logic                   in_ready,
    input  logic [NUM_LANES-1:0]   lane_mask,
    output logic [NUM_LANES-1:0]   out_valid,
    output logic [NUM_LANES*W-1:0] out_data,
    input  logic [NUM_LANES-1:0]   out_ready,
    output logic [SEL_W-1:0]       sel,
    output logic                   busy,
    output logic [CNT_W-1:0]       delivered
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]       data_q, data_d;
    logic [CNT_W-1:0]   delivered_q, delivered_d;

    logic [SEL_W-1:0]   grant;
    logic               found;
    logic               accept;
    logic               transfer;
    logic [NUM_LANES-1:0] sel_onehot;

    rr_pick8 u_pick (
        .mask  (lane_mask),
        .ptr   (ptr_q),
        .grant (grant),
        .found (found)
    );

    // found is equivalent to lane_mask != 0. The held lane is freed in the same
    // cycle it is consumed, so HOLD can still accept when out_ready[sel] is set.
    // Reset forces in_ready low even though the state already reads IDLE.
    assign in_ready = !rst && (state_q == IDLE || out_ready[sel_q]) && found;
    assign accept   = in_valid && in_ready;
    assign transfer = (state_q == HOLD) && out_ready[sel_q];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        delivered_d = delivered_q;
        if (transfer) begin
            delivered_d = delivered_q + CNT_W'(1);
            state_d     = IDLE;
        end
        // An accept in the same cycle as a transfer overrides the return to
        // IDLE and loads the new word and lane.
        if (accept) begin
            state_d = HOLD;
            sel_d   = grant;
            ptr_d   = grant;
            data_d  = in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            // Last grant reads as lane 7 so the first search starts at lane 0.
            ptr_q       <= SEL_W'(NUM_LANES - 1);
            // NOTE: the data register is reset too, so no stale word survives
            // a reset taken during HOLD and out_data is defined from the start.
            data_q      <= '0;
            delivered_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            delivered_q <= delivered_d;
        end
    end

    // Demux: one-hot decode of sel gates both the valid bits and the data lanes.
    assign sel_onehot = NUM_LANES'(1) << sel_q;
    assign out_valid  = (state_q == HOLD) ? sel_onehot : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign out_data[i*W +: W] = {W{out_valid[i]}} & data_q;
    end

    assign sel       = sel_q;
    assign busy      = (state_q == HOLD);
    assign delivered = delivered_q;

endmodule : demux_scheduler
